avst_pkt_arbiter: RTL
=====================

Name: avst_pkt_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one Avalon-ST sink among N_SRC Avalon-ST packet sources (for example, several beat-generator sources feeding one downstream parser).
- Grants one source at a time and holds the grant from the SOP beat through the EOP beat, so packets never interleave.
- Sits between the source bank and the single downstream consumer. The data path is a combinational mux; only the grant and state are registered.

Parameters:
- N_SRC, 4, number of requesting sources (2..8)
- WIDTH, 64, data bus width in bits
- EMPTY_WIDTH, $clog2(WIDTH/8), width of the empty field
- ID_W, $clog2(N_SRC), width of the grant index

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_data  in  N_SRC*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N_SRC  per-source valid
- in_sop  in  N_SRC  per-source start of packet
- in_eop  in  N_SRC  per-source end of packet
- in_empty  in  N_SRC*EMPTY_WIDTH  per-source empty field
- in_ready  out  N_SRC  per-source ready (one-hot or zero)
- out_data  out  WIDTH  muxed data
- out_valid  out  1  muxed valid
- out_sop  out  1  muxed sop
- out_eop  out  1  muxed eop
- out_empty  out  EMPTY_WIDTH  muxed empty
- out_ready  in  1  sink ready
- grant_id  out  ID_W  index of the current owner (valid while busy=1)
- busy  out  1  1 while in LOCKED
- err_no_sop  out  1  sticky; first accepted beat of a grant had sop=0

Behaviour:
- Reset (rst=1 at a clk edge):
  - state<=IDLE, grant_id<=0, last_grant<=N_SRC-1, err_no_sop<=0.
  - Reset mid-packet aborts the packet; no flush.
  - During IDLE all out_* fields and in_ready are 0.
- States:
  - IDLE: no owner. Outputs: out_valid=0, in_ready=0.
    - If any in_valid is set, pick the first set bit searching from (last_grant+1) mod N_SRC upward, with wrap.
    - Register the pick in grant_id and go to LOCKED.
    - Arbitration latency is 1 cycle: the winner's first beat can be accepted no earlier than the cycle after its valid is seen.
  - LOCKED: the owner is grant_id.
    - out_{data,valid,sop,eop,empty} = in_*[grant_id], purely combinational.
    - in_ready[grant_id] = out_ready; all other in_ready bits are 0.
    - A beat transfers when out_valid and out_ready are both 1.
    - On a transferred beat with out_eop=1: last_grant<=grant_id, next state IDLE.
    - The next grant appears one cycle later, so there is at least one idle bubble cycle between packets.
- Single-beat packets: sop=1 and eop=1 on the same beat is legal. The grant is released after that one transfer.
- Backpressure and owner gaps:
  - Owner valid dropping mid-packet: the grant is held indefinitely with no timeout. out_valid follows the owner.
  - out_ready=0: the beat is held and the grant is unchanged.
- err_no_sop: set on the first transferred beat after entering LOCKED if out_sop=0. Stays set until rst. The packet is still forwarded normally.
- SOP with no preceding EOP: an SOP beat arriving while LOCKED after the first beat is forwarded unchanged and not flagged.
- Requesters whose valid drops while not granted are simply not considered. No request latching.
- Fairness: with all N_SRC continuously requesting, grants rotate 0,1,...,N_SRC-1,0,...
- busy = (state==LOCKED).

Decomposition:
- Package avst_pkg:
  - arb_state_t enum {IDLE, LOCKED}
  - default WIDTH=64
  - function empty_width(width)
- Sub-module rr_picker:
  - Combinational.
  - Inputs: req[N_SRC], last[ID_W].
  - Outputs: any, idx[ID_W] (rotate-priority encoder).
- The top level holds the FSM, the grant and last_grant registers, the mux, and the error flag.

Test Plan:
1. Reset then idle: rst high for 2 cycles, in_valid=0 -> all outputs 0, busy=0, grant_id=0, err_no_sop=0.
2. Single source, 3 beats: src2 drives a 3-beat packet (FFFF_FFFF_FFFF_FFFF sop, EEEE_EEEE_EEEE_EEEE, DDDD_DDDD_DDDD_DDDD eop empty=3), out_ready=1 -> grant_id=2 one cycle after valid; 3 consecutive beats appear with matching sop/eop/empty; busy drops the cycle after eop.
3. Round-robin: all four sources each present continuous 2-beat packets -> grant order 0,1,2,3,0; every packet is contiguous with no interleaving; exactly one idle bubble between packets.
4. Backpressure: out_ready toggles 1,0,0,1 during src1's packet -> each beat is held while ready=0; in_ready[1] mirrors out_ready; other in_ready bits stay 0; no beat is lost or duplicated.
5. Single-beat packets and missing SOP: src0 sends one beat with sop=1, eop=1 -> released after 1 transfer. src3 then starts with sop=0 -> packet forwarded and err_no_sop=1, staying set.
6. Reset mid-packet: rst asserted on beat 2 of 3 from src1 -> next cycle IDLE, out_valid=0, last_grant resets, and src0 wins the next arbitration against src1.

Source files
------------

// File: rtl/avst_pkg.sv
// Shared types and helpers for the Avalon-ST packet arbiter.
package avst_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_WIDTH = 64;

  // Width of the Avalon-ST empty field for a given data width in bits.
  function automatic int empty_width(input int width);
    return (width > 8) ? $clog2(width / 8) : 1;
  endfunction

endpackage

// File: rtl/avst_pkt_arbiter_rr_picker.sv
// Rotating-priority encoder: first set req bit searching upward from last+1, with wrap.
module rr_picker #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  int best_d;

  // Distance from last+1 (mod N_SRC); the smallest distance among requesters wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    best_d = N_SRC;
    for (int i = 0; i < N_SRC; i++) begin
      if (req[i] && (((i + 2 * N_SRC - int'(last) - 1) % N_SRC) < best_d)) begin
        best_d = (i + 2 * N_SRC - int'(last) - 1) % N_SRC;
        idx    = ID_W'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avst_pkt_arbiter.sv
// Packet-atomic round-robin arbiter: one Avalon-ST sink shared by N_SRC sources,
// grant held from the first accepted beat through the EOP beat.
module avst_pkt_arbiter
  import avst_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int EMPTY_WIDTH = empty_width(WIDTH),
  parameter int ID_W        = $clog2(N_SRC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SRC*WIDTH-1:0]       in_data,
  input  logic [N_SRC-1:0]             in_valid,
  input  logic [N_SRC-1:0]             in_sop,
  input  logic [N_SRC-1:0]             in_eop,
  input  logic [N_SRC*EMPTY_WIDTH-1:0] in_empty,
  output logic [N_SRC-1:0]             in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [EMPTY_WIDTH-1:0]       out_empty,
  input  logic                         out_ready,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy,
  output logic                         err_no_sop
);

  // Handshake: a beat moves on a side when its valid and ready are both 1 at the
  // clk edge; valid never waits on ready, and ready here is the sink's ready
  // routed only to the owner.

  arb_state_t      state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic            first_beat;
  logic            xfer;

  rr_picker #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_picker (
    .req  (in_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign busy = (state == LOCKED);
  assign xfer = busy & out_valid & out_ready;

  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_empty = '0;
    in_ready  = '0;
    if (state == LOCKED) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (grant_id == ID_W'(i)) begin
          out_data    = in_data[i*WIDTH +: WIDTH];
          out_valid   = in_valid[i];
          out_sop     = in_sop[i];
          out_eop     = in_eop[i];
          out_empty   = in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
          in_ready[i] = out_ready;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(N_SRC - 1);
      err_no_sop <= 1'b0;
      first_beat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id   <= pick_idx;
            first_beat <= 1'b1;
            state      <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer) begin
            first_beat <= 1'b0;
            // Only the opening beat of a grant is expected to carry SOP.
            if (first_beat && !out_sop) begin
              err_no_sop <= 1'b1;
            end
            if (out_eop) begin
              last_grant <= grant_id;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
